hazard_ctrl_mdu: RTL and testbench
==================================

Name: hazard_ctrl_mdu

Overview:
- Next-generation hazard controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Provides the following:
  - E-stage operand forwarding from M and W.
  - Load-use stall, gated by operand use and excluding x0.
  - Control-redirect flush.
  - Multi-cycle stall sequencer for an iterative multiply/divide unit (MDU) that occupies E.
  - Saturating performance counters for stall and redirect cycles.
- Sits beside the pipeline registers; its stall/flush outputs drive their enables and clears.

Parameters:
- REG_AW, 5: register-index width.
- MDU_LAT, 4: total cycles an MDU instruction occupies E; must be >= 1; 1 means no stall.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- rs1D, rs2D  in  REG_AW  D-stage source indices
- use_rs1D, use_rs2D  in  1  D instruction actually reads rs1/rs2
- rs1E, rs2E, rdE  in  REG_AW  E-stage indices
- memreadE  in  1  E instruction is a load
- mdu_opE  in  1  E instruction is an MDU op
- pcsrcE  in  1  taken branch/jump resolved in E
- rdM, rdW  in  REG_AW  destination indices in M and W
- regwriteM, regwriteW  in  1  M/W write the register file
- forwardaE, forwardbE  out  2  00 = regfile, 01 = W result, 10 = M ALU result
- stallF, stallD, stallE  out  1  hold the corresponding pipeline register
- flushD, flushE, flushM  out  1  insert a bubble into that register
- mdu_busy  out  1  MDU sequencing in progress this cycle
- stall_cnt, redirect_cnt  out  CNT_W  performance counters

Behaviour:
- Forwarding (combinational, per operand, A shown; B identical with rs2E):
  - 10 if regwriteM && rdM != 0 && rdM == rs1E.
  - Else 01 if regwriteW && rdW != 0 && rdW == rs1E.
  - Else 00.
  - M has priority over W.
  - Forwarding stays active during stalls.
- load_use = memreadE && rdE != 0 && ((use_rs1D && rdE == rs1D) || (use_rs2D && rdE == rs2D)).
- MDU sequencer:
  - Register cnt_q, width clog2(MDU_LAT) (min 1), reset 0.
  - mdu_busy = mdu_opE && (cnt_q != MDU_LAT-1), combinational.
  - Each clock:
    - If rst or pcsrcE: cnt_q <= 0.
    - Else if mdu_busy: cnt_q <= cnt_q + 1.
    - Else if mdu_opE: cnt_q <= 0 (last cycle; instruction leaves E).
    - Otherwise cnt_q holds.
  - Net effect: an MDU op stays in E for exactly MDU_LAT cycles, with MDU_LAT-1 stall cycles.
- Stall/flush priority, highest first; all outputs default 0:
  1. pcsrcE: flushD = 1, flushE = 1. All stalls are 0 and mdu_busy is forced to 0. Redirect overrides load-use.
  2. mdu_busy: stallF = stallD = stallE = 1, flushM = 1. flushE = 0, so the MDU op is never killed. A coincident load_use is absorbed; it is re-evaluated once E advances.
  3. load_use: stallF = stallD = 1, flushE = 1.
- Performance counters:
  - stall_cnt increments every cycle stallF = 1.
  - redirect_cnt increments every cycle pcsrcE = 1.
  - Both saturate at all-ones and do not wrap.
- Reset:
  - rst zeroes cnt_q, stall_cnt and redirect_cnt.
  - Combinational outputs follow their inputs; with cnt_q = 0 and all inputs 0, every output is 0.
  - Reset in the middle of an MDU op abandons it; cnt_q is 0 on the next cycle.
- Back-to-back MDU ops: the second sees cnt_q = 0 on its first E cycle and gets a full MDU_LAT occupancy.

Decomposition:
- Shared package (pipeline types): fwd_sel_t enum {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10}; the REG_AW default constant.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instanced twice for the performance counters.
- The sequencer and the priority logic stay in the top module.

Test Plan:
- Forward priority: regwriteM = regwriteW = 1, rdM = rdW = rs1E = 5 -> forwardaE = 10. Set rdM = 0 -> forwardaE = 01. rs2E = 0 with rdW = 0 -> forwardbE = 00.
- Load-use: memreadE = 1, rdE = 7, rs2D = 7, use_rs2D = 1 -> stallF = stallD = flushE = 1 for one cycle. With use_rs2D = 0 -> no stall. With rdE = 0 -> no stall.
- MDU, MDU_LAT = 4: hold mdu_opE = 1 -> stallF/D/E, flushM and mdu_busy are all 1 for exactly 3 cycles, 0 on the 4th; stall_cnt advances by 3.
- MDU_LAT = 1 variant: mdu_opE = 1 -> mdu_busy never asserts; no stalls.
- Redirect vs load-use: pcsrcE = 1 together with load_use conditions -> flushD = flushE = 1, stallF = 0; redirect_cnt increments by 1.
- rst asserted on the 2nd busy cycle of an MDU op -> next cycle cnt_q = 0 and both counters = 0. A fresh mdu_opE then stalls a full 3 cycles.
- Saturation with CNT_W = 2: hold stallF for 5 cycles -> stall_cnt sticks at 3.

Source files
------------

// File: rtl/hazard_ctrl_mdu_pkg.sv
// Shared pipeline types for the hazard controller.
//   fwd_sel_t  : E-stage operand source select (regfile / W result / M ALU result)
//   REG_AW_DEF : default register-index width
//   fwd_pick   : resolves M/W hits into a select, M winning because it is younger
package hazard_ctrl_mdu_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl_mdu.sv
// Hazard controller for a 5-stage pipeline with an iterative MDU in E.
//   Inputs : D/E/M/W register indices and use/write qualifiers, memreadE (load in E),
//            mdu_opE (MDU op in E), pcsrcE (redirect resolved in E), clk, rst (sync, high)
//   Outputs: forwardaE/forwardbE operand selects, stallF/D/E, flushD/E/M,
//            mdu_busy, stall_cnt, redirect_cnt
// Priority of pipeline control: redirect > MDU occupancy > load-use.
module hazard_ctrl_mdu
    import hazard_ctrl_mdu_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic              use_rs1D,
    input  logic              use_rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic              memreadE,
    input  logic              mdu_opE,
    input  logic              pcsrcE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regwriteM,
    input  logic              regwriteW,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  redirect_cnt
);

    // cycle index of the MDU op currently in E; LAST is its final (non-stalling) cycle
    localparam int            CW   = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MDU_LAT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_load_use;
    logic          w_mdu_busy;
    fwd_sel_t      w_fwd_a;
    fwd_sel_t      w_fwd_b;

    // Forwarding is purely index-based and stays live through stalls
    always_comb begin
        w_fwd_a = fwd_pick(regwriteM && (rdM != '0) && (rdM == rs1E),
                           regwriteW && (rdW != '0) && (rdW == rs1E));
        w_fwd_b = fwd_pick(regwriteM && (rdM != '0) && (rdM == rs2E),
                           regwriteW && (rdW != '0) && (rdW == rs2E));
    end

    assign forwardaE = w_fwd_a;
    assign forwardbE = w_fwd_b;

    assign w_load_use = memreadE && (rdE != '0) &&
                        ((use_rs1D && (rdE == rs1D)) || (use_rs2D && (rdE == rs2D)));

    // A redirect kills the MDU op, so it must not also hold the pipe
    assign w_mdu_busy = mdu_opE && !pcsrcE && (r_cnt != LAST);
    assign mdu_busy   = w_mdu_busy;

    always_ff @(posedge clk) begin
        if (rst || pcsrcE) begin
            r_cnt <= '0;
        end else if (w_mdu_busy) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (mdu_opE) begin
            r_cnt <= '0;
        end
    end

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (pcsrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (w_mdu_busy) begin
            // E is held, M gets bubbles; a pending load-use is re-checked once E moves
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (w_load_use) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stallF),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pcsrcE),
        .count (redirect_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_mdu.sv
module tb_hazard_ctrl_mdu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       use_rs1D, use_rs2D, memreadE, mdu_opE, pcsrcE, regwriteM, regwriteW;

    // a_ : defaults (MDU_LAT=4, CNT_W=32); b_ : MDU_LAT=1; c_ : CNT_W=2
    logic [1:0]  a_fa, a_fb, b_fa, b_fb, c_fa, c_fb;
    logic        a_sF, a_sD, a_sE, a_fD, a_fE, a_fM, a_busy;
    logic        b_sF, b_sD, b_sE, b_fD, b_fE, b_fM, b_busy;
    logic        c_sF, c_sD, c_sE, c_fD, c_fE, c_fM, c_busy;
    logic [31:0] a_scnt, a_rcnt, b_scnt, b_rcnt;
    logic [1:0]  c_scnt, c_rcnt;

    hazard_ctrl_mdu u_main (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .memreadE(memreadE), .mdu_opE(mdu_opE), .pcsrcE(pcsrcE),
        .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .forwardaE(a_fa), .forwardbE(a_fb), .stallF(a_sF), .stallD(a_sD), .stallE(a_sE),
        .flushD(a_fD), .flushE(a_fE), .flushM(a_fM), .mdu_busy(a_busy),
        .stall_cnt(a_scnt), .redirect_cnt(a_rcnt));

    hazard_ctrl_mdu #(.MDU_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .memreadE(memreadE), .mdu_opE(mdu_opE), .pcsrcE(pcsrcE),
        .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .forwardaE(b_fa), .forwardbE(b_fb), .stallF(b_sF), .stallD(b_sD), .stallE(b_sE),
        .flushD(b_fD), .flushE(b_fE), .flushM(b_fM), .mdu_busy(b_busy),
        .stall_cnt(b_scnt), .redirect_cnt(b_rcnt));

    hazard_ctrl_mdu #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .memreadE(memreadE), .mdu_opE(mdu_opE), .pcsrcE(pcsrcE),
        .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .forwardaE(c_fa), .forwardbE(c_fb), .stallF(c_sF), .stallD(c_sD), .stallE(c_sE),
        .flushD(c_fD), .flushE(c_fE), .flushM(c_fM), .mdu_busy(c_busy),
        .stall_cnt(c_scnt), .redirect_cnt(c_rcnt));

    int n_pass = 0;
    int n_total = 0;

    // Reference model: cycles the current MDU instruction has already spent in E
    int occ4 = 0;
    int occ1 = 0;
    longint m_stall4 = 0;
    longint m_stall1 = 0;
    longint m_redir = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {fa, fb, stallF, stallD, stallE, flushD, flushE, flushM, busy}
    function automatic logic [10:0] ref_comb(input int occ, input int lat);
        logic lu, busy;
        logic [5:0] ctl;
        lu   = memreadE && rdE != 0 && ((use_rs1D && rdE == rs1D) || (use_rs2D && rdE == rs2D));
        busy = mdu_opE && !pcsrcE && (occ < lat - 1);
        if (pcsrcE)    ctl = 6'b000110;
        else if (busy) ctl = 6'b111001;
        else if (lu)   ctl = 6'b110010;
        else           ctl = 6'b000000;
        return {ref_fwd(rs1E), ref_fwd(rs2E), ctl, busy};
    endfunction

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // One clock: compare combinational outputs mid-cycle, advance the model, compare counters
    task automatic cyc();
        logic [10:0] e4, e1;
        @(negedge clk);
        e4 = ref_comb(occ4, 4);
        e1 = ref_comb(occ1, 1);
        chk("comb_main", {a_fa, a_fb, a_sF, a_sD, a_sE, a_fD, a_fE, a_fM, a_busy}, e4);
        chk("comb_lat1", {b_fa, b_fb, b_sF, b_sD, b_sE, b_fD, b_fE, b_fM, b_busy}, e1);
        chk("comb_sat",  {c_fa, c_fb, c_sF, c_sD, c_sE, c_fD, c_fE, c_fM, c_busy}, e4);
        @(posedge clk);
        if (rst) begin
            m_stall4 = 0; m_stall1 = 0; m_redir = 0;
        end else begin
            m_stall4 += e4[6];
            m_stall1 += e1[6];
            m_redir  += pcsrcE;
        end
        if (rst || pcsrcE) begin
            occ4 = 0; occ1 = 0;
        end else if (mdu_opE) begin
            occ4 = (occ4 + 1) % 4;
            occ1 = (occ1 + 1) % 1;
        end
        #1;
        chk("stall_cnt_main", a_scnt, sat(m_stall4, 64'hFFFF_FFFF));
        chk("redir_cnt_main", a_rcnt, sat(m_redir, 64'hFFFF_FFFF));
        chk("stall_cnt_lat1", b_scnt, sat(m_stall1, 64'hFFFF_FFFF));
        chk("stall_cnt_sat",  c_scnt, sat(m_stall4, 3));
        chk("redir_cnt_sat",  c_rcnt, sat(m_redir, 3));
    endtask

    task automatic idle();
        rst = 0; rs1D = 0; rs2D = 0; use_rs1D = 0; use_rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0;
        memreadE = 0; mdu_opE = 0; pcsrcE = 0; rdM = 0; rdW = 0; regwriteM = 0; regwriteW = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        cyc();
        rst = 0;
        #2;
        chk("reset_outputs", {a_fa, a_fb, a_sF, a_sD, a_sE, a_fD, a_fE, a_fM, a_busy}, 0);
        chk("reset_stall_cnt", a_scnt, 0);
        cyc();

        // Forwarding priority
        regwriteM = 1; regwriteW = 1; rdM = 5; rdW = 5; rs1E = 5;
        #2; chk("fwd_m_prio", a_fa, 2'b10);
        cyc();
        rdM = 0;
        #2; chk("fwd_w", a_fa, 2'b01);
        rs2E = 0; rdW = 0;
        #2; chk("fwd_b_x0", a_fb, 2'b00);
        cyc();
        idle();

        // Load-use
        memreadE = 1; rdE = 7; rs2D = 7; use_rs2D = 1;
        #2; chk("load_use", {a_sF, a_sD, a_fE}, 3'b111);
        cyc();
        use_rs2D = 0;
        #2; chk("load_use_unused", {a_sF, a_sD, a_fE}, 3'b000);
        cyc();
        use_rs2D = 1; rdE = 0; rs2D = 0;
        #2; chk("load_use_x0", {a_sF, a_sD, a_fE}, 3'b000);
        cyc();
        idle();

        // MDU occupancy: three stall cycles then release
        mdu_opE = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("mdu_busy_seq", {a_busy, a_sF, a_sD, a_sE, a_fM}, (i < 3) ? 5'b11111 : 5'b00000);
            chk("mdu_lat1_idle", {b_busy, b_sF}, 2'b00);
            cyc();
        end
        idle();

        // Redirect beats load-use
        memreadE = 1; rdE = 9; rs1D = 9; use_rs1D = 1; pcsrcE = 1;
        #2; chk("redirect_prio", {a_fD, a_fE, a_sF}, 3'b110);
        cyc();
        idle();

        // Reset on the second busy cycle abandons the op
        mdu_opE = 1;
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        chk("rst_mid_stall", a_scnt, 0);
        chk("rst_mid_redir", a_rcnt, 0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("mdu_after_rst", a_busy, (i < 3) ? 1'b1 : 1'b0);
            cyc();
        end
        idle();

        // Saturation of a 2-bit counter
        rst = 1;
        cyc();
        rst = 0;
        memreadE = 1; rdE = 3; rs1D = 3; use_rs1D = 1;
        for (int i = 0; i < 5; i++) cyc();
        chk("sat_stick", c_scnt, 2'd3);
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rs1D = 5'($urandom_range(0, 7)); rs2D = 5'($urandom_range(0, 7));
            rs1E = 5'($urandom_range(0, 7)); rs2E = 5'($urandom_range(0, 7));
            rdE  = 5'($urandom_range(0, 7)); rdM  = 5'($urandom_range(0, 7));
            rdW  = 5'($urandom_range(0, 7));
            use_rs1D  = 1'($urandom_range(0, 1)); use_rs2D  = 1'($urandom_range(0, 1));
            regwriteM = 1'($urandom_range(0, 1)); regwriteW = 1'($urandom_range(0, 1));
            memreadE  = ($urandom_range(0, 2) == 0);
            mdu_opE   = (occ4 > 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            pcsrcE    = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 59) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
